dice_roll_scheduler: RTL and testbench

- Sequencer and arbiter sitting in front of dice_traffic_mux; owns its button and sel inputs.
- Shares the single dice between NUM_REQ requesters using a round-robin req/gnt/done handshake.
- Holds button for a per-requester number of cycles, then waits a settle window and captures the throw.
- Returns the mux to traffic-light mode whenever no roll is in progress.

---
 rtl/dice_roll_scheduler.sv | 167 ++++++++++++++++
 tb/tb_dice_roll_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_scheduler.sv
// dice_roll_scheduler
// Round-robin sequencer that shares one dice_traffic_mux among NUM_REQ
// requesters. A granted requester gets the button held for its own hold
// length, then a settle window, then the mux result is captured and
// returned with a done pulse. Between rolls the mux is left in traffic mode.
//
// Optional build macro: DICE_THROW_CHECK_EN
//   defined   -> err latches when a captured throw is 0 or 7 (sticky to rst)
//   undefined -> err is tied low and no check logic is built
module dice_roll_scheduler #(
   parameter int NUM_REQ = 2,
   parameter int HOLD_W  = 4,
   parameter int SETTLE  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*HOLD_W-1:0] hold_len,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [2:0]                throw_out,
   output logic                      busy,
   output logic                      err,
   output logic                      mux_button,
   output logic                      mux_sel,
   input  logic [2:0]                mux_result
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   // Sequencer states
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HOLD    = 2'd1;
   localparam logic [1:0] ST_SETTLE  = 2'd2;
   localparam logic [1:0] ST_CAPTURE = 2'd3;

   logic [1:0]        state;
   logic [IDX_W-1:0]  rr_ptr;      // first requester to consider next
   logic [IDX_W-1:0]  cur_idx;     // requester being served
   logic [HOLD_W-1:0] hold_cnt;    // remaining button cycles minus one
   logic [1:0]        settle_cnt;  // remaining settle cycles minus one

   logic [HOLD_W-1:0] hold_arr [NUM_REQ];
   logic [IDX_W-1:0]  cand;
   logic              pick_valid;
   logic [IDX_W-1:0]  pick_idx;
   logic [HOLD_W-1:0] pick_raw;
   logic [HOLD_W-1:0] pick_h;
   logic [IDX_W-1:0]  next_ptr;
   logic              capture_fire;

   // Unpack the flattened hold-length bus into one field per requester
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         hold_arr[i] = hold_len[i*HOLD_W +: HOLD_W];
      end
   end

   // Round-robin pick: first set req at or after rr_ptr, wrapping
   // NOTE: every variable written here gets a default first, otherwise the
   // paths that skip an assignment would infer a latch.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (!pick_valid && req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   // Effective hold length of the picked requester; zero means one cycle
   always_comb begin
      pick_raw = hold_arr[pick_idx];
      pick_h   = (pick_raw == '0) ? HOLD_W'(1) : pick_raw;
   end

   // Pointer value after serving cur_idx, and the capture edge qualifier
   always_comb begin
      next_ptr     = (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;
      capture_fire = (state == ST_SETTLE) && (settle_cnt == '0);
   end

   // Main sequencer: grant, hold, settle, capture, with registered outputs
   // NOTE: state and outputs use non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         rr_ptr     <= '0;
         cur_idx    <= '0;
         hold_cnt   <= '0;
         settle_cnt <= '0;
         gnt        <= '0;
         done       <= '0;
         throw_out  <= 3'd0;
         busy       <= 1'b0;
         mux_button <= 1'b0;
         mux_sel    <= 1'b1;
      end else begin
         // gnt and done are single-cycle pulses
         gnt  <= '0;
         done <= '0;
         case (state)
            ST_IDLE: begin
               mux_sel    <= 1'b1;
               mux_button <= 1'b0;
               busy       <= 1'b0;
               if (pick_valid) begin
                  state         <= ST_HOLD;
                  cur_idx       <= pick_idx;
                  hold_cnt      <= pick_h - 1'b1;
                  gnt[pick_idx] <= 1'b1;
                  busy          <= 1'b1;
                  mux_sel       <= 1'b0;
                  mux_button    <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (hold_cnt == '0) begin
                  state      <= ST_SETTLE;
                  mux_button <= 1'b0;
                  settle_cnt <= 2'(SETTLE - 1);
               end else begin
                  hold_cnt <= hold_cnt - 1'b1;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt == '0) begin
                  state         <= ST_CAPTURE;
                  throw_out     <= mux_result;
                  done[cur_idx] <= 1'b1;
                  mux_sel       <= 1'b1;
                  rr_ptr        <= next_ptr;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            ST_CAPTURE: begin
               // One mandatory traffic-mode IDLE cycle follows every roll
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef DICE_THROW_CHECK_EN
   // Sticky flag for a captured throw outside 1..6
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (capture_fire && (mux_result == 3'd0 || mux_result == 3'd7)) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Directed bench for dice_roll_scheduler with a scoreboard of expected rolls.
module tb_dice_roll_scheduler;

   localparam int NUM_REQ = 2;
   localparam int HOLD_W  = 4;
   localparam int SETTLE  = 1;

   logic                      clk;
   logic                      rst;
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*HOLD_W-1:0] hold_len;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        done;
   logic [2:0]                throw_out;
   logic                      busy;
   logic                      err;
   logic                      mux_button;
   logic                      mux_sel;
   logic [2:0]                mux_result;

   typedef struct {
      int         idx;
      int         h;
      logic [2:0] throw_v;
   } roll_t;

   roll_t sb[$];
   int    vectors     = 0;
   int    miscompares = 0;
   logic  exp_err     = 1'b0;

   dice_roll_scheduler #(
      .NUM_REQ(NUM_REQ),
      .HOLD_W (HOLD_W),
      .SETTLE (SETTLE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .hold_len  (hold_len),
      .gnt       (gnt),
      .done      (done),
      .throw_out (throw_out),
      .busy      (busy),
      .err       (err),
      .mux_button(mux_button),
      .mux_sel   (mux_sel),
      .mux_result(mux_result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue an expected roll and raise the request
   task automatic request(input int idx, input int h, input logic [2:0] t);
      roll_t e;
      logic [31:0] hv;
      hv = h;
      hold_len[idx*HOLD_W +: HOLD_W] = hv[HOLD_W-1:0];
      e.idx     = idx;
      e.h       = (h == 0) ? 1 : h;
      e.throw_v = t;
      sb.push_back(e);
      req[idx] = 1'b1;
   endtask

   task automatic wait_gnt(output int n);
      n = 0;
      while (gnt == '0 && n < 40) begin
         tick();
         n++;
      end
   endtask

   // Follow one roll cycle by cycle from its grant through the IDLE after done
   task automatic run_roll(input bit drop_req, input int pulse_idx, input int exp_wait);
      roll_t              e;
      int                 n;
      logic [NUM_REQ-1:0] oh;
      wait_gnt(n);
      check("gnt_seen", 32'(gnt != '0), 32'd1);
      if (gnt == '0) return;
      if (exp_wait > 0) check("gnt_gap", 32'(n), 32'(exp_wait));
      e  = sb[0];
      oh = NUM_REQ'(1) << e.idx;
      mux_result = e.throw_v;
      if (drop_req) req[e.idx] = 1'b0;
      check("gnt_idx", 32'(gnt), 32'(oh));
      check("gnt_busy", 32'(busy), 32'd1);
      check("gnt_sel", 32'(mux_sel), 32'd0);
      check("gnt_button", 32'(mux_button), 32'd1);
      for (int c = 1; c < e.h; c++) begin
         tick();
         check("hold_button", 32'(mux_button), 32'd1);
         check("hold_gnt", 32'(gnt), 32'd0);
         if (pulse_idx >= 0 && c == 1) req[pulse_idx] = 1'b1;
         if (pulse_idx >= 0 && c == 2) req[pulse_idx] = 1'b0;
      end
      for (int s = 0; s < SETTLE; s++) begin
         tick();
         check("settle_button", 32'(mux_button), 32'd0);
         check("settle_sel", 32'(mux_sel), 32'd0);
         check("settle_done", 32'(done), 32'd0);
         check("settle_gnt", 32'(gnt), 32'd0);
      end
      tick();
      e = sb.pop_front();
`ifdef DICE_THROW_CHECK_EN
      if (e.throw_v == 3'd0 || e.throw_v == 3'd7) exp_err = 1'b1;
`endif
      check("done_idx", 32'(done), 32'(oh));
      check("done_throw", 32'(throw_out), 32'(e.throw_v));
      check("done_sel", 32'(mux_sel), 32'd1);
      check("done_busy", 32'(busy), 32'd1);
      check("done_gnt", 32'(gnt), 32'd0);
      check("done_err", 32'(err), 32'(exp_err));
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_sel", 32'(mux_sel), 32'd1);
   endtask

   initial begin
      int n;
      rst        = 1'b1;
      req        = '0;
      hold_len   = '0;
      mux_result = 3'd0;
      tick();
      tick();
      rst = 1'b0;

      // Reset values, then 20 idle cycles in traffic mode
      check("rst_throw", 32'(throw_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      for (int i = 0; i < 20; i++) begin
         check("idle_sel", 32'(mux_sel), 32'd1);
         check("idle_button", 32'(mux_button), 32'd0);
         check("idle_gnt", 32'(gnt), 32'd0);
         check("idle_done", 32'(done), 32'd0);
         tick();
      end

      // Single requester 0, hold 3, throw 3
      request(0, 3, 3'd3);
      run_roll(1'b1, -1, 0);

      // Requester 1 with hold 0 behaves as hold 1
      request(1, 0, 3'd5);
      run_roll(1'b1, -1, 0);

      // Both requesting continuously: strict alternation, 5 cycles apart
      hold_len = {4'd2, 4'd2};
      begin
         roll_t e;
         e.h = 2;
         e.idx = 0; e.throw_v = 3'd1; sb.push_back(e);
         e.idx = 1; e.throw_v = 3'd2; sb.push_back(e);
         e.idx = 0; e.throw_v = 3'd6; sb.push_back(e);
         e.idx = 1; e.throw_v = 3'd4; sb.push_back(e);
      end
      req = 2'b11;
      run_roll(1'b0, -1, 0);
      run_roll(1'b0, -1, 1);
      run_roll(1'b0, -1, 1);
      run_roll(1'b0, -1, 1);
      req = '0;

      // Requester 0 pulses while requester 1 is being served: never granted
      request(1, 4, 3'd6);
      run_roll(1'b1, 0, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("no_late_gnt", 32'(gnt), 32'd0);
      end

      // Out-of-range throw followed by a valid one
      request(0, 2, 3'd7);
      run_roll(1'b1, -1, 0);
      request(0, 1, 3'd4);
      run_roll(1'b1, -1, 0);

      // Reset in the middle of HOLD drops the roll immediately
      hold_len[HOLD_W-1:0] = 4'd5;
      req = 2'b01;
      wait_gnt(n);
      check("mid_gnt_seen", 32'(gnt), 32'd1);
      tick();
      tick();
      check("mid_hold_button", 32'(mux_button), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      exp_err = 1'b0;
      check("mid_rst_button", 32'(mux_button), 32'd0);
      check("mid_rst_sel", 32'(mux_sel), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_err", 32'(err), 32'd0);
      req = '0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick();
         check("mid_no_done", 32'(done), 32'd0);
         check("mid_no_gnt", 32'(gnt), 32'd0);
      end

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
